// File: rtl/jt900h_pkg.sv
// Shared definitions for the JT900H register bank: operand size codes, register-code
// field positions and the lane extract/merge helpers used by the read and write ports.
package jt900h_pkg;

   typedef enum logic [1:0] {
      BYTE_SZ = 2'd0,
      WORD_SZ = 2'd1,
      LONG_SZ = 2'd2
   } size_e;

   typedef enum logic {
      DMP_IDLE = 1'b0,
      DMP_RUN  = 1'b1
   } dmp_state_e;

   localparam int SEL_PTR_BIT  = 7;
   localparam int SEL_BANK_MSB = 6;
   localparam int SEL_BANK_LSB = 4;
   localparam int SEL_REG_MSB  = 3;
   localparam int SEL_REG_LSB  = 2;

   // XSP is the last pointer, placed after all accumulator banks in the flat index space.
   function automatic int xsp_index(input int nbank, input int nptr);
      return 4*nbank + nptr - 1;
   endfunction

   function automatic logic [31:0] lane_read(input logic [31:0] v, input logic [1:0] size,
                                             input logic [1:0] lane);
      logic [31:0] r;
      case (size_e'(size))
         BYTE_SZ: r = {24'd0, v[{lane, 3'b000} +: 8]};
         WORD_SZ: r = {16'd0, v[{lane[1], 4'b0000} +: 16]};
         default: r = v;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] size, input logic [1:0] lane);
      logic [31:0] r;
      r = old;
      case (size_e'(size))
         BYTE_SZ: r[{lane, 3'b000} +: 8]     = d[7:0];
         WORD_SZ: r[{lane[1], 4'b0000} +: 16] = d[15:0];
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/jt900h_regbank_dump.sv
// Byte-serial dump sequencer: walks every register byte in order with a valid/ready
// handshake, asking the parent for the next byte through o_fetch one cycle ahead.
module jt900h_regbank_dump
   import jt900h_pkg::*;
#(
   parameter int NB = 80,
   parameter int CW = $clog2(NB)
)(
   input  logic          rst,
   input  logic          clk,
   input  logic          i_cen,
   input  logic          i_start,
   input  logic          i_ready,
   input  logic [7:0]    i_byte,
   output logic [CW-1:0] o_fetch,
   output logic          o_busy,
   output logic          o_valid,
   output logic          o_last,
   output logic [7:0]    o_data
);

   dmp_state_e    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic          r_valid;
   logic          r_last;
   logic [7:0]    r_data;

   // The byte is captured when the counter moves, so a stalled byte never changes while
   // register writes still show up in bytes fetched later.
   assign o_fetch = (r_state == DMP_IDLE) ? '0 : r_cnt + CW'(1);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= DMP_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_data  <= 8'd0;
      end else if (i_cen) begin
         case (r_state)
            DMP_IDLE: begin
               if (i_start) begin
                  r_state <= DMP_RUN;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_valid <= 1'b1;
                  r_last  <= 1'b0;
                  r_data  <= i_byte;
               end
            end
            DMP_RUN: begin
               if (i_ready) begin
                  if (r_cnt == CW'(NB-1)) begin
                     r_state <= DMP_IDLE;
                     r_busy  <= 1'b0;
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                  end else begin
                     r_cnt  <= r_cnt + CW'(1);
                     r_data <= i_byte;
                     r_last <= (r_cnt == CW'(NB-2));
                  end
               end
            end
            default: r_state <= DMP_IDLE;
         endcase
      end
   end

   assign o_busy  = r_busy;
   assign o_valid = r_valid;
   assign o_last  = r_last;
   assign o_data  = r_data;

endmodule

// File: rtl/jt900h_regbank.sv
// JT900H banked general-register file: NBANK banks of XWA..XHL plus NPTR pointers,
// two sized read ports, one lane write port, the RFP bank pointer and a debug dump port.
module jt900h_regbank
   import jt900h_pkg::*;
#(
   parameter int          NBANK  = 4,
   parameter int          NPTR   = 4,
   parameter logic [31:0] SP_RST = 32'h100,
   parameter bit          FWD    = 1'b0,
   localparam int         BW     = $clog2(NBANK)
)(
   input  logic          rst,
   input  logic          clk,
   input  logic          cen,
   input  logic [7:0]    rd0_sel,
   output logic [31:0]   rd0_data,
   input  logic [1:0]    rd0_size,
   input  logic [7:0]    rd1_sel,
   output logic [31:0]   rd1_data,
   input  logic [1:0]    rd1_size,
   input  logic          wr_en,
   input  logic [7:0]    wr_sel,
   input  logic [1:0]    wr_size,
   input  logic [31:0]   wr_data,
   input  logic          rfp_inc,
   input  logic          rfp_dec,
   input  logic          rfp_ld,
   input  logic [BW-1:0] rfp_din,
   output logic [BW-1:0] rfp,
   output logic [31:0]   xsp,
   input  logic          dmp_start,
   output logic          dmp_busy,
   output logic          dmp_valid,
   input  logic          dmp_ready,
   output logic [7:0]    dmp_data,
   output logic          dmp_last
);

   localparam int NACC = 4*NBANK;
   localparam int NREG = NACC + NPTR;
   localparam int IW   = $clog2(NREG);
   localparam int XSP  = xsp_index(NBANK, NPTR);
   localparam int NB   = 4*NREG;
   localparam int CW   = $clog2(NB);

   logic [31:0]   r_regs [NREG];
   logic [BW-1:0] r_rfp;

   // Bank bits above BW mark an absent bank rather than aliasing into another register.
   function automatic logic sel_ok(input logic [7:0] sel);
      if (sel[SEL_PTR_BIT])
         return int'(sel[SEL_REG_MSB:SEL_REG_LSB]) < NPTR;
      return int'(sel[SEL_BANK_MSB:SEL_BANK_LSB]) < NBANK;
   endfunction

   function automatic logic [IW-1:0] sel_idx(input logic [7:0] sel);
      if (sel[SEL_PTR_BIT])
         return IW'(NACC + int'(sel[SEL_REG_MSB:SEL_REG_LSB]));
      return IW'({sel[SEL_BANK_MSB:SEL_BANK_LSB], sel[SEL_REG_MSB:SEL_REG_LSB]});
   endfunction

   logic          w_wr_ok;
   logic [IW-1:0] w_wr_idx;
   logic          w_wr_go;
   logic [31:0]   w_wr_old;
   logic [31:0]   w_wr_new;

   assign w_wr_ok  = sel_ok(wr_sel);
   assign w_wr_idx = sel_idx(wr_sel);
   assign w_wr_go  = cen & wr_en & w_wr_ok;
   assign w_wr_old = w_wr_ok ? r_regs[w_wr_idx] : 32'd0;
   assign w_wr_new = lane_merge(w_wr_old, wr_data, wr_size, wr_sel[1:0]);

   logic [7:0]  w_rd_sel  [2];
   logic [1:0]  w_rd_size [2];
   logic [31:0] w_rd_data [2];

   assign w_rd_sel[0]  = rd0_sel;
   assign w_rd_sel[1]  = rd1_sel;
   assign w_rd_size[0] = rd0_size;
   assign w_rd_size[1] = rd1_size;

   // NOTE: every combinational output gets a default before any branch so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_rd_data[p] = 32'd0;
         if (sel_ok(w_rd_sel[p])) begin
            if (FWD && w_wr_go && (sel_idx(w_rd_sel[p]) == w_wr_idx))
               w_rd_data[p] = lane_read(w_wr_new, w_rd_size[p], w_rd_sel[p][1:0]);
            else
               w_rd_data[p] = lane_read(r_regs[sel_idx(w_rd_sel[p])], w_rd_size[p],
                                        w_rd_sel[p][1:0]);
         end
      end
   end

   assign rd0_data = w_rd_data[0];
   assign rd1_data = w_rd_data[1];

   // NOTE: the array is reset explicitly because accumulators and XSP must come up at
   // known values; this keeps it in flops instead of a RAM macro.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            r_regs[i] <= (i == XSP) ? SP_RST : 32'd0;
         r_rfp <= '0;
      end else if (cen) begin
         if (w_wr_go)
            r_regs[w_wr_idx] <= w_wr_new;
         // Bank count is a power of two, so plain BW-bit arithmetic wraps correctly.
         if (rfp_ld)
            r_rfp <= rfp_din;
         else if (rfp_inc && !rfp_dec)
            r_rfp <= r_rfp + BW'(1);
         else if (rfp_dec && !rfp_inc)
            r_rfp <= r_rfp - BW'(1);
      end
   end

   assign rfp = r_rfp;
   assign xsp = r_regs[XSP];

   logic [CW-1:0] w_dmp_fetch;
   logic [31:0]   w_dmp_word;
   logic [7:0]    w_dmp_byte;

   always_comb begin
      w_dmp_word = 32'd0;
      if (int'(w_dmp_fetch[CW-1:2]) < NREG)
         w_dmp_word = r_regs[IW'(w_dmp_fetch[CW-1:2])];
   end

   assign w_dmp_byte = w_dmp_word[{w_dmp_fetch[1:0], 3'b000} +: 8];

   jt900h_regbank_dump #(
      .NB (NB),
      .CW (CW)
   ) u_dump (
      .rst     (rst),
      .clk     (clk),
      .i_cen   (cen),
      .i_start (dmp_start),
      .i_ready (dmp_ready),
      .i_byte  (w_dmp_byte),
      .o_fetch (w_dmp_fetch),
      .o_busy  (dmp_busy),
      .o_valid (dmp_valid),
      .o_last  (dmp_last),
      .o_data  (dmp_data)
   );

endmodule

// File: tb/tb_jt900h_regbank.sv
// Directed bench for jt900h_regbank: vector table for the read/write ports, then hand
// sequences for RFP, forwarding, cen gating and the dump handshake.
module tb_jt900h_regbank;

   localparam int NREG = 20;
   localparam int NB   = 80;

   logic        rst, clk, cen;
   logic [7:0]  rd0_sel, rd1_sel, wr_sel;
   logic [1:0]  rd0_size, rd1_size, wr_size;
   logic [31:0] wr_data;
   logic        wr_en, rfp_inc, rfp_dec, rfp_ld;
   logic [1:0]  rfp_din;
   logic        dmp_start, dmp_ready;

   logic [31:0] rd0_data, rd1_data, xsp;
   logic [1:0]  rfp;
   logic        dmp_busy, dmp_valid, dmp_last;
   logic [7:0]  dmp_data;

   logic [31:0] f_rd0_data, f_rd1_data, f_xsp;
   logic [1:0]  f_rfp;
   logic        f_dmp_busy, f_dmp_valid, f_dmp_last;
   logic [7:0]  f_dmp_data;

   jt900h_regbank #(.NBANK(4), .NPTR(4), .SP_RST(32'h100), .FWD(1'b0)) u_dut (
      .rst(rst), .clk(clk), .cen(cen),
      .rd0_sel(rd0_sel), .rd0_data(rd0_data), .rd0_size(rd0_size),
      .rd1_sel(rd1_sel), .rd1_data(rd1_data), .rd1_size(rd1_size),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_size(wr_size), .wr_data(wr_data),
      .rfp_inc(rfp_inc), .rfp_dec(rfp_dec), .rfp_ld(rfp_ld), .rfp_din(rfp_din),
      .rfp(rfp), .xsp(xsp),
      .dmp_start(dmp_start), .dmp_busy(dmp_busy), .dmp_valid(dmp_valid),
      .dmp_ready(dmp_ready), .dmp_data(dmp_data), .dmp_last(dmp_last)
   );

   jt900h_regbank #(.NBANK(4), .NPTR(4), .SP_RST(32'h100), .FWD(1'b1)) u_fwd (
      .rst(rst), .clk(clk), .cen(cen),
      .rd0_sel(rd0_sel), .rd0_data(f_rd0_data), .rd0_size(rd0_size),
      .rd1_sel(rd1_sel), .rd1_data(f_rd1_data), .rd1_size(rd1_size),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_size(wr_size), .wr_data(wr_data),
      .rfp_inc(rfp_inc), .rfp_dec(rfp_dec), .rfp_ld(rfp_ld), .rfp_din(rfp_din),
      .rfp(f_rfp), .xsp(f_xsp),
      .dmp_start(dmp_start), .dmp_busy(f_dmp_busy), .dmp_valid(f_dmp_valid),
      .dmp_ready(dmp_ready), .dmp_data(f_dmp_data), .dmp_last(f_dmp_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr_en;
      logic [7:0]  wr_sel;
      logic [1:0]  wr_size;
      logic [31:0] wr_data;
      logic [7:0]  s0;
      logic [1:0]  z0;
      logic [31:0] e0;
      logic [7:0]  s1;
      logic [1:0]  z1;
      logic [31:0] e1;
   } vec_t;

   vec_t        vecs [10];
   logic [31:0] exp_regs [NREG];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [7:0] sel, input logic [1:0] size, input logic [31:0] d);
      wr_en = 1'b1; wr_sel = sel; wr_size = size; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   function automatic logic [7:0] exp_byte(input int b);
      logic [31:0] w;
      w = exp_regs[b/4];
      return w[(b%4)*8 +: 8];
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int got;
      int guard;

      rst = 1'b1; cen = 1'b1;
      rd0_sel = 8'h00; rd0_size = 2'd2; rd1_sel = 8'h8C; rd1_size = 2'd2;
      wr_en = 1'b0; wr_sel = 8'h00; wr_size = 2'd0; wr_data = 32'h0;
      rfp_inc = 1'b0; rfp_dec = 1'b0; rfp_ld = 1'b0; rfp_din = 2'd0;
      dmp_start = 1'b0; dmp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst_xsp", xsp, 32'h100);
      check("rst_rfp", 32'(rfp), 32'd0);
      check("rst_dmp_valid", 32'(dmp_valid), 32'd0);
      check("rst_dmp_busy", 32'(dmp_busy), 32'd0);
      check("rst_xwa0", rd0_data, 32'h0);

      // Reads are checked before the edge, so they show state prior to that row's write.
      vecs[0] = '{1'b0, 8'h00, 2'd0, 32'h0,        8'h00, 2'd2, 32'h0,        8'h8C, 2'd2, 32'h100};
      vecs[1] = '{1'b1, 8'h14, 2'd2, 32'h12345678, 8'h14, 2'd2, 32'h0,        8'h8C, 2'd2, 32'h100};
      vecs[2] = '{1'b1, 8'h16, 2'd0, 32'hFFFFFFAA, 8'h14, 2'd2, 32'h12345678, 8'h17, 2'd0, 32'h12};
      vecs[3] = '{1'b0, 8'h00, 2'd0, 32'h0,        8'h14, 2'd2, 32'h12AA5678, 8'h16, 2'd0, 32'hAA};
      vecs[4] = '{1'b1, 8'h16, 2'd1, 32'h1234BEEF, 8'h14, 2'd1, 32'h5678,     8'h16, 2'd1, 32'h12AA};
      vecs[5] = '{1'b1, 8'h40, 2'd2, 32'hDEADBEEF, 8'h14, 2'd2, 32'hBEEF5678, 8'h40, 2'd2, 32'h0};
      vecs[6] = '{1'b1, 8'h80, 2'd2, 32'h00001234, 8'h80, 2'd2, 32'h0,        8'h40, 2'd2, 32'h0};
      vecs[7] = '{1'b0, 8'h00, 2'd0, 32'h0,        8'h80, 2'd2, 32'h1234,     8'h81, 2'd0, 32'h12};
      vecs[8] = '{1'b1, 8'h8C, 2'd1, 32'hFFFF7777, 8'h8C, 2'd0, 32'h00,       8'h8D, 2'd0, 32'h01};
      vecs[9] = '{1'b0, 8'h00, 2'd0, 32'h0,        8'h8C, 2'd2, 32'h7777,     8'h15, 2'd0, 32'h56};

      for (int i = 0; i < 10; i++) begin
         wr_en = vecs[i].wr_en; wr_sel = vecs[i].wr_sel;
         wr_size = vecs[i].wr_size; wr_data = vecs[i].wr_data;
         rd0_sel = vecs[i].s0; rd0_size = vecs[i].z0;
         rd1_sel = vecs[i].s1; rd1_size = vecs[i].z1;
         #1;
         check($sformatf("vec%0d_rd0", i), rd0_data, vecs[i].e0);
         check($sformatf("vec%0d_rd1", i), rd1_data, vecs[i].e1);
         step();
      end
      wr_en = 1'b0;
      check("xsp_after_word_write", xsp, 32'h7777);

      // Same-cycle forwarding: word then byte into XDE bank2.
      wr_en = 1'b1; wr_sel = 8'h28; wr_size = 2'd1; wr_data = 32'h0000CAFE;
      rd0_sel = 8'h28; rd0_size = 2'd1; rd1_sel = 8'h28; rd1_size = 2'd2;
      #1;
      check("fwd1_word", f_rd0_data, 32'hCAFE);
      check("fwd1_long", f_rd1_data, 32'h0000CAFE);
      check("fwd0_word_old", rd0_data, 32'h0);
      step();
      wr_sel = 8'h2B; wr_size = 2'd0; wr_data = 32'h00000011;
      #1;
      check("fwd1_byte_merge", f_rd1_data, 32'h1100CAFE);
      check("fwd0_byte_old", rd1_data, 32'h0000CAFE);
      step();
      wr_en = 1'b0;
      #1;
      check("xde2_after", rd1_data, 32'h1100CAFE);

      // cen low blocks writes.
      cen = 1'b0;
      write_reg(8'h00, 2'd2, 32'hFFFFFFFF);
      cen = 1'b1;
      rd0_sel = 8'h00; rd0_size = 2'd2;
      #1;
      check("cen_blocks_write", rd0_data, 32'h0);

      // RFP sequence.
      rfp_ld = 1'b1; rfp_din = 2'd3;
      #1;
      check("rfp_ld_same_cycle_old", 32'(rfp), 32'd0);
      step();
      check("rfp_ld3", 32'(rfp), 32'd3);
      rfp_ld = 1'b0; rfp_inc = 1'b1;
      step();
      check("rfp_inc_wrap", 32'(rfp), 32'd0);
      rfp_inc = 1'b0; rfp_dec = 1'b1;
      step();
      check("rfp_dec_wrap", 32'(rfp), 32'd3);
      rfp_inc = 1'b1; rfp_dec = 1'b1;
      step();
      check("rfp_inc_dec_hold", 32'(rfp), 32'd3);
      rfp_ld = 1'b1; rfp_din = 2'd2; rfp_dec = 1'b0;
      step();
      check("rfp_ld_priority", 32'(rfp), 32'd2);
      rfp_ld = 1'b0; cen = 1'b0;
      step();
      check("rfp_cen_frozen", 32'(rfp), 32'd2);
      cen = 1'b1; rfp_inc = 1'b0;

      // Fresh state for the dump.
      rst = 1'b1; #2 rst = 1'b0;
      step();
      for (int i = 0; i < NREG; i++) exp_regs[i] = 32'h0;
      exp_regs[19] = 32'h100;
      write_reg(8'h00, 2'd2, 32'h04030201); exp_regs[0]  = 32'h04030201;
      write_reg(8'h14, 2'd2, 32'h12345678); exp_regs[5]  = 32'h12345678;
      write_reg(8'h3C, 2'd2, 32'hA1B2C3D4); exp_regs[15] = 32'hA1B2C3D4;
      write_reg(8'h80, 2'd2, 32'h0000BEEF); exp_regs[16] = 32'h0000BEEF;

      dmp_ready = 1'b0; dmp_start = 1'b1;
      step();
      dmp_start = 1'b0;
      check("dmp_valid_first", 32'(dmp_valid), 32'd1);
      check("dmp_busy_first", 32'(dmp_busy), 32'd1);
      check("dmp_b0", 32'(dmp_data), 32'h01);
      dmp_ready = 1'b1;
      step();
      check("dmp_b1", 32'(dmp_data), 32'h02);
      dmp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("dmp_stall_hold%0d", i), 32'(dmp_data), 32'h02);
      end
      cen = 1'b0; dmp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check($sformatf("dmp_cen_hold%0d", i), 32'(dmp_data), 32'h02);
      end
      cen = 1'b1;

      got = 1; guard = 0;
      while (got < NB && guard < 400) begin
         if (dmp_valid) begin
            check($sformatf("dmp_byte%0d", got), 32'(dmp_data), 32'(exp_byte(got)));
            check($sformatf("dmp_last%0d", got), 32'(dmp_last), (got == NB-1) ? 32'd1 : 32'd0);
            if (got == 10) begin
               wr_en = 1'b1; wr_sel = 8'h3C; wr_size = 2'd2; wr_data = 32'h55667788;
               exp_regs[15] = 32'h55667788;
            end
            if (got == 20) dmp_start = 1'b1;
            got++;
         end
         step();
         wr_en = 1'b0; dmp_start = 1'b0;
         guard++;
      end
      check("dmp_byte_count", 32'(got), 32'(NB));
      check("dmp_busy_end", 32'(dmp_busy), 32'd0);
      check("dmp_valid_end", 32'(dmp_valid), 32'd0);

      // Reset in the middle of a dump.
      dmp_ready = 1'b1; dmp_start = 1'b1;
      step();
      dmp_start = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(dmp_busy), 32'd0);
      check("midrst_valid", 32'(dmp_valid), 32'd0);
      check("midrst_data", 32'(dmp_data), 32'd0);
      check("midrst_xsp", xsp, 32'h100);
      #1 rst = 1'b0;
      step();
      check("midrst_idle", 32'(dmp_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
